load_store_unit: RTL

Sits directly upstream of the word-addressed data memory in the processor's memory-access path. Accepts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests from the execute/control side, checks alignment, and converts each request into word-indexed read/write strobes. Sub-word stores use read-modify-write. Load data is lane-extracted and sign-/zero-extended before being returned to writeback.

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/lsu_if.sv | 36 +++
 rtl/lsu_lane_align.sv | 50 +++++
 rtl/load_store_unit.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    localparam int unsigned DEPTH_DEF  = 64;
    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W     = 32;

    // Access size encoding as presented on req_size.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4,
        ERR  = 3'd5
    } state_e;

    // Request fields held for the lifetime of one access.
    typedef struct packed {
        logic              we;
        size_e             size;
        logic              uns;
        logic [1:0]        off;
        logic [DATA_W-1:0] wdata;
    } req_ctl_t;

    // Misalignment or reserved size for a given byte offset.
    function automatic logic align_err(size_e size, logic [1:0] off);
        logic err;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = off[0];
            SZ_WORD: err = (off != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response and data-memory bus of the load/store unit.
interface lsu_if #(
    parameter int unsigned ADDR_W = lsu_pkg::ADDR_W_DEF
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              rsp_valid;
    logic              rsp_err;
    logic [31:0]       rsp_rdata;

    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic              dm_read;
    logic              dm_write;
    logic [31:0]       dm_rdata;

    // The load/store unit itself.
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, dm_rdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata, dm_addr, dm_wdata, dm_read, dm_write
    );

    // Requester and memory side combined.
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, dm_rdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata, dm_addr, dm_wdata, dm_read, dm_write
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian lane extraction/extension for loads and lane merge for stores.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0] word_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [1:0]        off_i,
    input  size_e             size_i,
    input  logic              unsigned_i,
    output logic [DATA_W-1:0] ld_data_c_o,
    output logic [DATA_W-1:0] st_word_c_o
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign byte_sh = {off_i, 3'b000};
    assign half_sh = {off_i[1], 4'b0000};
    assign ld_byte = 8'(word_i >> byte_sh);
    assign ld_half = 16'(word_i >> half_sh);

    // Select lanes by size; reserved size leaves the word untouched.
    always_comb begin
        ld_data_c_o = word_i;
        st_word_c_o = word_i;
        case (size_i)
            SZ_BYTE: begin
                ld_data_c_o = unsigned_i ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
                st_word_c_o = (word_i & ~(32'h0000_00FF << byte_sh))
                            | (32'(wdata_i[7:0]) << byte_sh);
            end
            SZ_HALF: begin
                ld_data_c_o = unsigned_i ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
                st_word_c_o = (word_i & ~(32'h0000_FFFF << half_sh))
                            | (32'(wdata_i[15:0]) << half_sh);
            end
            SZ_WORD: begin
                ld_data_c_o = word_i;
                st_word_c_o = wdata_i;
            end
            default: begin
                ld_data_c_o = word_i;
                st_word_c_o = word_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: byte-addressed requests to word-indexed memory strobes,
// read-modify-write for sub-word stores, extended load data to writeback.
// Optional macro LSU_RANGE_CHECK_EN: word index >= DEPTH is reported as an error.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic  clk,
    input  logic  rst_n,
    lsu_if.slave  bus
);

`ifdef LSU_RANGE_CHECK_EN
    localparam logic RANGE_CHK = 1'b1;
`else
    localparam logic RANGE_CHK = 1'b0;
`endif

    state_e            state_q, state_d;
    req_ctl_t          ctl_q, ctl_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
    logic [31:0]       dm_wdata_q, dm_wdata_d;
    logic              dm_read_q, dm_read_d;
    logic              dm_write_q, dm_write_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              req_ready_q, req_ready_d;

    logic [ADDR_W-1:0] req_idx;
    size_e             req_size;
    logic              req_err;
    logic [31:0]       cap_word;
    logic [31:0]       ld_data;
    logic [31:0]       st_word;

    assign req_idx  = bus.req_addr >> 2;
    assign req_size = size_e'(bus.req_size);
    assign req_err  = align_err(req_size, bus.req_addr[1:0])
                    | (RANGE_CHK & (req_idx >= ADDR_W'(DEPTH)));

    // Memory data is only valid during CAP; later states use the captured copy.
    assign cap_word = (state_q == CAP) ? bus.dm_rdata : word_q;

    lsu_lane_align u_align (
        .word_i      (cap_word),
        .wdata_i     (ctl_q.wdata),
        .off_i       (ctl_q.off),
        .size_i      (ctl_q.size),
        .unsigned_i  (ctl_q.uns),
        .ld_data_c_o (ld_data),
        .st_word_c_o (st_word)
    );

    // State and registered outputs; reset drops strobes and discards the access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ctl_q       <= '0;
            word_q      <= '0;
            dm_addr_q   <= '0;
            dm_wdata_q  <= '0;
            dm_read_q   <= 1'b0;
            dm_write_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            ctl_q       <= ctl_d;
            word_q      <= word_d;
            dm_addr_q   <= dm_addr_d;
            dm_wdata_q  <= dm_wdata_d;
            dm_read_q   <= dm_read_d;
            dm_write_q  <= dm_write_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            req_ready_q <= req_ready_d;
        end
    end

    // Next state plus the output values that go with it.
    always_comb begin
        state_d     = state_q;
        ctl_d       = ctl_q;
        word_d      = word_q;
        dm_addr_d   = dm_addr_q;
        dm_wdata_d  = dm_wdata_q;
        dm_read_d   = 1'b0;
        dm_write_d  = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    ctl_d.we    = bus.req_we;
                    ctl_d.size  = req_size;
                    ctl_d.uns   = bus.req_unsigned;
                    ctl_d.off   = bus.req_addr[1:0];
                    ctl_d.wdata = bus.req_wdata;
                    dm_addr_d   = req_idx;
                    if (req_err) begin
                        state_d     = ERR;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (bus.req_we && (req_size == SZ_WORD)) begin
                        state_d    = WR;
                        dm_write_d = 1'b1;
                        dm_wdata_d = bus.req_wdata;
                    end else begin
                        state_d   = RD;
                        dm_read_d = 1'b1;
                    end
                end
            end
            RD: begin
                state_d = CAP;
            end
            CAP: begin
                word_d = bus.dm_rdata;
                if (ctl_q.we) begin
                    state_d    = WR;
                    dm_write_d = 1'b1;
                    dm_wdata_d = st_word;
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = ld_data;
                end
            end
            WR: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.dm_addr   = dm_addr_q;
    assign bus.dm_wdata  = dm_wdata_q;
    assign bus.dm_read   = dm_read_q;
    assign bus.dm_write  = dm_write_q;

endmodule
